// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg : op encodings and FSM states for the multiply/divide unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mul_div_unit_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_cond_negate.sv
// ---------------------------------------------------------------------------
// mdu_cond_negate : two's-complement negation when neg_i is set
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit : iterative radix-2 signed/unsigned multiply and divide, EX stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int ACC_W = 2*WIDTH + 1;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbzo_q, dbzo_d;

  logic             w_signed;
  logic             w_is_div;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [ACC_W-1:0] w_mul_next;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH-1:0] w_rem_new;
  logic [ACC_W-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

  assign w_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign w_is_div = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);

  mdu_cond_negate #(.WIDTH(WIDTH)) u_mag_a (
    .in_i (src1_i),
    .neg_i(w_signed & src1_i[WIDTH-1]),
    .out_o(w_mag_a)
  );

  mdu_cond_negate #(.WIDTH(WIDTH)) u_mag_b (
    .in_i (src2_i),
    .neg_i(w_signed & src2_i[WIDTH-1]),
    .out_o(w_mag_b)
  );

  // Multiply step: {carry,upper} += multiplicand when multiplier LSB set, then shift right.
  assign w_mul_sum  = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {1'b0, w_mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift {rem,quot} left, keep the trial difference if it did not borrow.
  assign w_rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, opnd_q};
  assign w_rem_new  = w_diff[WIDTH+1] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_div_next = {1'b0, w_rem_new, acc_q[WIDTH-2:0], ~w_diff[WIDTH+1]};

  mdu_cond_negate #(.WIDTH(2*WIDTH)) u_prod_fix (
    .in_i (acc_q[2*WIDTH-1:0]),
    .neg_i(sign_a_q ^ sign_b_q),
    .out_o(w_prod_fix)
  );

  mdu_cond_negate #(.WIDTH(WIDTH)) u_quo_fix (
    .in_i (acc_q[WIDTH-1:0]),
    .neg_i(sign_a_q ^ sign_b_q),
    .out_o(w_quo_fix)
  );

  // With a zero divisor the loop leaves the dividend magnitude here, so this also restores src1.
  mdu_cond_negate #(.WIDTH(WIDTH)) u_rem_fix (
    .in_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i(sign_a_q),
    .out_o(w_rem_fix)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbzo_d   = dbzo_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            stall_o  = 1'b1;
            state_d  = S_CALC;
            cnt_d    = CNT_W'(WIDTH-1);
            is_div_d = w_is_div;
            sign_a_d = w_signed & src1_i[WIDTH-1];
            sign_b_d = w_signed & src2_i[WIDTH-1];
            dbz_d    = w_is_div & (src2_i == '0);
            opnd_d   = w_is_div ? w_mag_b : w_mag_a;
            acc_d    = {1'b0, {WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
          end
        end
        S_CALC: begin
          stall_o = 1'b1;
          acc_d   = is_div_q ? w_div_next : w_mul_next;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          stall_o = 1'b1;
          state_d = S_DONE;
          dbzo_d  = dbz_q;
          if (is_div_q) begin
            hi_d = w_rem_fix;
            lo_d = dbz_q ? {WIDTH{1'b1}} : w_quo_fix;
          end else begin
            hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
            lo_d = w_prod_fix[WIDTH-1:0];
          end
        end
        S_DONE: begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbzo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbzo_q   <= dbzo_d;
    end
  end

  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbzo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit : directed vectors, corner sequences and random ops vs. model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_div_unit;

  logic        clk, rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        stall, done, dbz;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_hi, last_lo;
  logic        last_z;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .start_i      (start),
    .op_i         (op),
    .src1_i       (src1),
    .src2_i       (src2),
    .flush_i      (flush),
    .stall_o      (stall),
    .done_o       (done),
    .hi_o         (hi),
    .lo_o         (lo),
    .div_by_zero_o(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: plain 64-bit signed/unsigned arithmetic with truncating division.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin pu = {32'b0, a} * {32'b0, b}; h = pu[63:32]; l = pu[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0];
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
  endfunction

  // Issues one op in an idle cycle and waits for done_o, scrambling inputs after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic z,
                       output int lat, output int stall_err);
    @(posedge clk); #1;
    start = 1'b1; op = o; src1 = a; src2 = b;
    #1;
    stall_err = (stall !== 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (stall !== 1'b1) stall_err++;
      @(posedge clk); #1;
      lat++;
    end
    if (stall !== 1'b0) stall_err++;
    h = hi; l = lo; z = dbz;
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                           input logic ez);
    logic [31:0] h, l;
    logic z;
    int lat, serr;
    do_op(o, a, b, h, l, z, lat, serr);
    chk({tag, "_hi"}, 64'(h), 64'(eh));
    chk({tag, "_lo"}, 64'(l), 64'(el));
    chk({tag, "_dbz"}, 64'(z), 64'(ez));
    chk({tag, "_latency"}, 64'(lat), 64'd34);
    chk({tag, "_stall"}, 64'(serr), 64'd0);
    last_hi = eh; last_lo = el; last_z = ez;
  endtask

  initial begin
    logic [31:0] eh, el, h1, l1;
    logic ez;
    int ndone, dlat;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[5] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[6] = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'b11, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0};
    vecs[8] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[9] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_stall", 64'(stall), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].z);
    end

    // Flush mid-divide: no done, stall drops with flush, results retained.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_stall_low", 64'(stall), 64'd0);
    chk("flush_no_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || stall !== 1'b0) ndone++;
      @(posedge clk); #1;
    end
    chk("flush_idle_after", 64'(ndone), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'(last_hi));
    chk("flush_lo_kept", 64'(lo), 64'(last_lo));
    chk("flush_dbz_kept", 64'(dbz), 64'(last_z));

    // Flush and start together in IDLE: nothing starts.
    start = 1'b1; flush = 1'b1; op = 2'b01; src1 = 32'd3; src2 = 32'd4;
    #1;
    chk("flush_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    chk("flush_start_no_done", 64'(ndone), 64'd0);
    chk("flush_start_lo_kept", 64'(lo), 64'(last_lo));

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if ($urandom_range(0, 9) == 0) rb = 32'hFFFF_FFFF;
      model(ro, ra, rb, eh, el, ez);
      run_check($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, eh, el, ez);
    end

    // Second start at cycle 5 must be ignored; exactly one done with the first result.
    model(2'b00, 32'd1234, 32'hFFFF_2243, eh, el, ez);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; src1 = 32'd1234; src2 = 32'hFFFF_2243;
    ndone = 0; dlat = 0; h1 = '0; l1 = '0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i == 5) begin start = 1'b1; op = 2'b11; src1 = 32'd77; src2 = 32'd5; end
      if (i == 6) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin dlat = i; h1 = hi; l1 = lo; end
      end
    end
    chk("restart_done_count", 64'(ndone), 64'd1);
    chk("restart_latency", 64'(dlat), 64'd34);
    chk("restart_hi", 64'(h1), 64'(eh));
    chk("restart_lo", 64'(l1), 64'(el));

    // Asynchronous reset at cycle 20 of a multiply.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; src1 = 32'h0001_2345; src2 = 32'h0000_0777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_stall", 64'(stall), 64'd0);
    chk("midreset_dbz", 64'(dbz), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    chk("midreset_no_done", 64'(ndone), 64'd0);
    run_check("post_reset_multu", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
